bc_fir_serial: RTL and testbench

Parametrised, time-multiplexed successor to the fixed 19-tap binary FIR. It keeps the tap-spaced delay line, where tap i sees the sample accepted i·SCALE samples earlier. The parallel multiplier array is replaced by a single multiply-accumulate unit stepped by a small state machine. Samples enter and results leave over valid/ready handshakes, and the result is rounded and saturated to a configurable output width. The block sits between the sample source and downstream binary/stochastic conversion logic in the FIR datapath.

---
 rtl/bc_fir_pkg.sv | 24 ++
 rtl/bc_fir_serial_if.sv | 25 ++
 rtl/bc_fir_mac.sv | 23 ++
 rtl/bc_fir_serial.sv | 84 ++++++++
 tb/tb_bc_fir_serial.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bc_fir_pkg.sv
// bc_fir_pkg: shared types, default coefficients and arithmetic helpers for bc_fir_serial
package bc_fir_pkg;
  localparam int N_DEF = 19;
  localparam logic signed [11:0] COEF_DEF [N_DEF] = '{
    12'sd3, 12'sd0, -12'sd21, 12'sd0, 12'sd78, 12'sd0, -12'sd237, 12'sd0, 12'sd943, 12'sd1533,
    12'sd943, 12'sd0, -12'sd237, 12'sd0, 12'sd78, 12'sd0, -12'sd21, 12'sd0, 12'sd3
  };
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;
  function automatic int acc_w(input int d, input int c, input int l);
    return d + c + $clog2(l);
  endfunction
  function automatic logic signed [31:0] coef_def(input int i);
    if (i < N_DEF) return 32'(COEF_DEF[i]);
    return 32'sd0;
  endfunction
  // round half up by adding half an LSB before the arithmetic shift, then clamp
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] a, input int frac, input int out_w);
    logic signed [63:0] r, hi, lo;
    r = frac > 0 ? (a + (64'sd1 <<< (frac - 1))) >>> frac : a;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/bc_fir_serial_if.sv
// bc_fir_serial_if: sample/result handshakes; coefficient write port only with FIR_COEF_LOAD_EN
interface bc_fir_serial_if #(
  parameter int DATA_W = 13,
  parameter int OUT_W = 13
`ifdef FIR_COEF_LOAD_EN
  , parameter int COEF_W = 12
  , parameter int LENGTH = 19
`endif
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [DATA_W-1:0] in_data;
  logic signed [OUT_W-1:0] out_data;
`ifdef FIR_COEF_LOAD_EN
  logic coef_we, coef_ready;
  logic [$clog2(LENGTH)-1:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  modport master (output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
                  input in_ready, out_valid, out_data, coef_ready);
  modport slave (input in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
                 output in_ready, out_valid, out_data, coef_ready);
`else
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/bc_fir_mac.sv
// bc_fir_mac: registered signed multiply-accumulate with synchronous clear and enable
module bc_fir_mac #(
  parameter int A_W = 13,
  parameter int B_W = 12,
  parameter int ACC_W = 30
) (
  input  logic clock_s,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_acc
);
  logic signed [A_W+B_W-1:0] w_prod;
  logic signed [ACC_W-1:0] r_acc;
  assign w_prod = i_a * i_b;
  assign o_acc = r_acc;
  always_ff @(posedge clock_s or negedge reset_n)
    if (!reset_n) r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en) r_acc <= r_acc + ACC_W'(w_prod);
endmodule

// File: rtl/bc_fir_serial.sv
// bc_fir_serial: time-multiplexed tap-spaced FIR, one MAC per cycle, rounded/saturated output.
// FIR_COEF_LOAD_EN adds a runtime-writable coefficient register file.
module bc_fir_serial
  import bc_fir_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int COEF_W = 12,
  parameter int LENGTH = 19,
  parameter int SCALE = 2,
  parameter int OUT_W = 13,
  parameter int FRAC = 11
) (
  input logic clock_s,
  input logic reset_n,
  bc_fir_serial_if.slave bus
);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, LENGTH);
  localparam int DL = (LENGTH - 1) * SCALE + 1;
  localparam int IW = $clog2(LENGTH + 1);
  state_e r_state, w_next;
  logic [IW-1:0] r_idx, w_sel;
  logic signed [DATA_W-1:0] r_dl [DL];
  logic signed [DATA_W-1:0] w_tap [LENGTH];
  logic signed [COEF_W-1:0] w_coef [LENGTH];
  logic signed [ACC_W-1:0] w_acc;
  logic signed [OUT_W-1:0] r_out;
  logic w_take, w_run, w_last;
  assign w_take = bus.in_valid && r_state == IDLE;
  assign w_run = r_state == MAC && r_idx != IW'(LENGTH);
  assign w_last = r_state == MAC && r_idx == IW'(LENGTH);
  assign w_sel = w_run ? r_idx : '0;
  assign bus.in_ready = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.out_data = r_out;
  for (genvar i = 0; i < LENGTH; i++) begin : g_tap
    assign w_tap[i] = r_dl[i*SCALE];
  end
`ifdef FIR_COEF_LOAD_EN
  logic signed [COEF_W-1:0] r_coef [LENGTH];
  assign bus.coef_ready = r_state == IDLE;
  always_ff @(posedge clock_s or negedge reset_n)
    if (!reset_n) for (int i = 0; i < LENGTH; i++) r_coef[i] <= COEF_W'(coef_def(i));
    else if (bus.coef_we && r_state == IDLE && {1'b0, bus.coef_addr} < ($clog2(LENGTH)+1)'(LENGTH))
      r_coef[bus.coef_addr] <= bus.coef_data;
  for (genvar i = 0; i < LENGTH; i++) begin : g_coef
    assign w_coef[i] = r_coef[i];
  end
`else
  for (genvar i = 0; i < LENGTH; i++) begin : g_coef
    assign w_coef[i] = COEF_W'(coef_def(i));
  end
`endif
  always_ff @(posedge clock_s or negedge reset_n)
    if (!reset_n) for (int i = 0; i < DL; i++) r_dl[i] <= '0;
    else if (w_take) begin
      r_dl[0] <= bus.in_data;
      for (int i = 1; i < DL; i++) r_dl[i] <= r_dl[i-1];
    end
  // one extra MAC-state cycle after the last product lets the result register see the final acc
  always_comb
    w_next = r_state == IDLE ? (w_take ? MAC : IDLE)
           : r_state == MAC  ? (w_last ? DONE : MAC)
           : (bus.out_ready ? IDLE : DONE);
  always_ff @(posedge clock_s or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_out <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) r_idx <= '0;
      else if (w_run) r_idx <= r_idx + IW'(1);
      if (w_last) r_out <= OUT_W'(sat_round(64'(w_acc), FRAC, OUT_W));
    end
  bc_fir_mac #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clock_s(clock_s),
    .reset_n(reset_n),
    .i_clr(w_take),
    .i_en(w_run),
    .i_a(w_tap[w_sel]),
    .i_b(w_coef[w_sel]),
    .o_acc(w_acc)
  );
endmodule

// File: tb/tb_bc_fir_serial.sv
// tb_bc_fir_serial: directed checks of bc_fir_serial; coefficient-load steps build with FIR_COEF_LOAD_EN
module tb_bc_fir_serial;
  logic clock_s = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int lat;
  localparam int C [19] = '{3, 0, -21, 0, 78, 0, -237, 0, 943, 1533, 943, 0, -237, 0, 78, 0, -21, 0, 3};
  bc_fir_serial_if bus ();
  bc_fir_serial dut (.clock_s(clock_s), .reset_n(reset_n), .bus(bus));
  always #5 clock_s = ~clock_s;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock_s) reset_n = 1'b0;
    @(negedge clock_s) reset_n = 1'b1;
  endtask

  task automatic accept(input logic signed [12:0] d);
    int k = 0;
    @(negedge clock_s);
    while (!bus.in_ready && k < 100) begin
      @(negedge clock_s);
      k++;
    end
    if (k >= 100) chk("in_ready_timeout", 32'(k), 0);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    @(posedge clock_s);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    @(negedge clock_s);
    while (!bus.out_valid && l < 100) begin
      @(negedge clock_s);
      l++;
    end
    if (l >= 100) chk("out_valid_timeout", 32'(l), 20);
  endtask

  task automatic push_chk(input string tag, input logic signed [12:0] d, input int exp);
    int l;
    accept(d);
    wait_out(l);
    chk(tag, 32'(bus.out_data), exp);
  endtask

`ifdef FIR_COEF_LOAD_EN
  task automatic wr(input int a, input int v);
    @(negedge clock_s);
    bus.coef_we = 1'b1;
    bus.coef_addr = 5'(a);
    bus.coef_data = 12'(v);
    @(posedge clock_s);
    #1 bus.coef_we = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
`ifdef FIR_COEF_LOAD_EN
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
`endif
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    @(negedge clock_s) reset_n = 1'b1;

    for (int k = 0; k < 37; k++) begin
      accept(k == 0 ? 13'sd2048 : 13'sd0);
      wait_out(lat);
      if (k == 0) chk("latency", 32'(lat), 20);
      chk($sformatf("impulse_%0d", k), 32'(bus.out_data), (k % 2 == 0) ? C[k/2] : 0);
    end

    do_reset();
    push_chk("half_k0", 13'sd1024, 2);
    push_chk("half_k1", 13'sd0, 0);
    push_chk("half_k2", 13'sd0, 0);
    push_chk("half_k3", 13'sd0, 0);
    push_chk("half_k4", 13'sd0, -10);

    do_reset();
    for (int k = 1; k <= 37; k++) begin
      accept(13'sd4095);
      wait_out(lat);
      if (k == 1) chk("dcpos_1", 32'(bus.out_data), 6);
      if (k == 5) chk("dcpos_5", 32'(bus.out_data), -36);
    end
    chk("dcpos_acc", 32'(dut.w_acc), 12551175);
    chk("dcpos_sat", 32'(bus.out_data), 4095);

    do_reset();
    for (int k = 1; k <= 37; k++) begin
      accept(-13'sd4096);
      wait_out(lat);
      if (k == 1) chk("dcneg_1", 32'(bus.out_data), -6);
    end
    chk("dcneg_sat", 32'(bus.out_data), -4096);

    do_reset();
    bus.out_ready = 1'b0;
    accept(13'sd2048);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 20);
    bus.in_valid = 1'b1;
    bus.in_data = 13'sd1024;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock_s);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_data", 32'(bus.out_data), 3);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clock_s);
    chk("bp_rel_in_ready", 32'(bus.in_ready), 1);
    chk("bp_rel_out_valid", 32'(bus.out_valid), 0);
    @(posedge clock_s);
    #1 bus.in_valid = 1'b0;
    wait_out(lat);
    chk("bp_held_latency", 32'(lat), 20);
    chk("bp_held_sample", 32'(bus.out_data), 2);

    do_reset();
    push_chk("rst_pre0", 13'sd4095, 6);
    push_chk("rst_pre1", 13'sd0, 0);
    push_chk("rst_pre2", 13'sd0, 0);
    accept(13'sd0);
    repeat (8) @(negedge clock_s);
    chk("mac_idx", 32'(dut.r_idx), 7);
    chk("mac_in_ready", 32'(bus.in_ready), 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clock_s) reset_n = 1'b1;
    push_chk("midrst_post", 13'sd2048, 3);

`ifdef FIR_COEF_LOAD_EN
    do_reset();
    @(negedge clock_s);
    chk("ld_coef_ready", 32'(bus.coef_ready), 1);
    wr(0, 100);
    for (int a = 1; a < 19; a++) wr(a, 0);
    push_chk("ld_impulse", 13'sd2048, 100);
    accept(13'sd2048);
    repeat (4) @(negedge clock_s);
    chk("ld_mac_coef_ready", 32'(bus.coef_ready), 0);
    wr(0, 5);
    wait_out(lat);
    chk("ld_during_mac", 32'(bus.out_data), 100);
    push_chk("ld_after_mac", 13'sd2048, 100);
    @(negedge clock_s);
    bus.coef_we = 1'b1;
    bus.coef_addr = 5'd0;
    bus.coef_data = 12'sd50;
    bus.in_valid = 1'b1;
    bus.in_data = 13'sd2048;
    @(posedge clock_s);
    #1;
    bus.coef_we = 1'b0;
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("ld_same_cycle", 32'(bus.out_data), 50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
